cpu_core_rv32i: RTL and testbench

Single-issue RV32I integer core: fetches from a combinational instruction port, executes in one cycle, and accesses a synchronous-read data memory port. Loads take two cycles; all other instructions take one. It is the top compute block of the processor. Test harnesses attach instruction/data memories and observe the register file hierarchically.

---
 rtl/cpu_core_rv32i_pkg.sv | 65 ++++++
 rtl/cpu_core_rv32i_if.sv | 46 ++++
 rtl/cpu_core_rv32i_reg_file.sv | 37 +++
 rtl/cpu_core_rv32i.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cpu_core_rv32i.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_core_rv32i_pkg.sv
// Shared definitions for the RV32I core: major opcodes, funct3 codes,
// the ALU operation set and the load/store access widths.
package cpu_core_rv32i_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // OP / OP-IMM funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        LS_BYTE,
        LS_HALF,
        LS_WORD
    } ls_width_e;

endpackage

// File: rtl/cpu_core_rv32i_if.sv
// Instruction-fetch, data-memory and debug signals of the RV32I core.
//   instr_addr        core -> imem  fetch address (PC)
//   instruction       imem -> core  instruction word, combinational
//   data_addr         core -> dmem  byte address of load/store
//   data_wdata        core -> dmem  store data replicated on byte lanes
//   data_rdata        dmem -> core  registered read word
//   data_we           core -> dmem  store strobe
//   data_be           core -> dmem  byte-lane enables
//   debug_pc          core -> obs   current PC
//   debug_instruction core -> obs   current instruction word
// Modport master is the core side, slave the memory/harness side.
interface cpu_core_rv32i_if;
    logic [31:0] instr_addr;
    logic [31:0] instruction;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] debug_pc;
    logic [31:0] debug_instruction;

    modport master (
        output instr_addr,
        input  instruction,
        output data_addr,
        output data_wdata,
        input  data_rdata,
        output data_we,
        output data_be,
        output debug_pc,
        output debug_instruction
    );

    modport slave (
        input  instr_addr,
        output instruction,
        input  data_addr,
        input  data_wdata,
        output data_rdata,
        input  data_we,
        input  data_be,
        input  debug_pc,
        input  debug_instruction
    );
endinterface

// File: rtl/cpu_core_rv32i_reg_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port. x0 always reads zero and ignores writes.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all)
//   rs1_addr/rs1_data   read port A
//   rs2_addr/rs2_data   read port B
//   we/rd_addr/rd_data  write port, takes effect at the rising edge
module cpu_core_rv32i_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] registers [0:31];

    // Reset wins over a write in the same cycle, so a load abandoned by
    // reset never lands in rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            registers[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : registers[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : registers[rs2_addr];

endmodule

// File: rtl/cpu_core_rv32i.sv
// Single-issue RV32I core. Every instruction executes in one cycle except
// loads, which use a second cycle (LOAD_WAIT) to consume the registered
// data memory read. Decode, immediates, ALU, branch compare and load/store
// lane alignment are all in this module; registers live in reg_file.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  master side of cpu_core_rv32i_if (fetch, data memory, debug)
module cpu_core_rv32i
    import cpu_core_rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    cpu_core_rv32i_if.master bus
);

    localparam logic [0:0] ST_EXEC      = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [0:0]  state;
    logic [0:0]  state_next;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct7_b5;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    alu_op_e     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    ls_width_e   ls_width;
    logic        load_ok;
    logic        store_ok;
    logic [31:0] mem_addr;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    logic        rd_we;
    logic [31:0] rd_wdata;

    // ---------------------------------------------------------------
    // Decode and immediates
    // ---------------------------------------------------------------
    assign instr     = bus.instruction;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7_b5 = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    cpu_core_rv32i_reg_file reg_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs1_data (rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rs2_data),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_wdata)
    );

    // ---------------------------------------------------------------
    // ALU
    // ---------------------------------------------------------------
    function automatic logic [31:0] alu_compute(input alu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         shamt;
        logic [31:0]        res;
        sa    = a;
        sb    = b;
        shamt = b[4:0];
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << shamt;
            ALU_SLT:  res = {31'd0, (sa < sb)};
            ALU_SLTU: res = {31'd0, (a < b)};
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $unsigned(sa >>> shamt);
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            default:  res = a + b;
        endcase
        return res;
    endfunction

    // Only OP (register form) uses funct7[5] to pick SUB; for OP-IMM the
    // same bit is part of the immediate, except for SRAI.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: alu_op = ((opcode == OP_OP) && funct7_b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_op = ALU_SLL;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_SRL_SRA: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            default:    alu_op = ALU_ADD;
        endcase
    end

    assign alu_b      = (opcode == OP_OP) ? rs2_data : imm_i;
    assign alu_result = alu_compute(alu_op, rs1_data, alu_b);

    // ---------------------------------------------------------------
    // Branch compare
    // ---------------------------------------------------------------
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               taken;
        sa = a;
        sb = b;
        case (f3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = (sa < sb);
            F3_BGE:  taken = (sa >= sb);
            F3_BLTU: taken = (a < b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // ---------------------------------------------------------------
    // Load/store alignment
    // ---------------------------------------------------------------
    assign ls_width = (funct3[1:0] == 2'b00) ? LS_BYTE :
                      (funct3[1:0] == 2'b01) ? LS_HALF : LS_WORD;

    // Reserved width encodings fall through as NOPs.
    assign load_ok  = (opcode == OP_LOAD) &&
                      ((funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                       (funct3 == F3_LBU) || (funct3 == F3_LHU));
    assign store_ok = (opcode == OP_STORE) &&
                      ((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));

    // Instruction and registers are stable across both load cycles, so this
    // sum also holds data_addr steady during LOAD_WAIT.
    assign mem_addr = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = rs2_data;
        case (ls_width)
            LS_BYTE: begin
                store_be    = 4'b0001 << mem_addr[1:0];
                store_wdata = {4{rs2_data[7:0]}};
            end
            LS_HALF: begin
                store_be    = 4'b0011 << {mem_addr[1], 1'b0};
                store_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = rs2_data;
            end
        endcase
    end

    always_comb begin
        case (mem_addr[1:0])
            2'd0:    load_byte = bus.data_rdata[7:0];
            2'd1:    load_byte = bus.data_rdata[15:8];
            2'd2:    load_byte = bus.data_rdata[23:16];
            default: load_byte = bus.data_rdata[31:24];
        endcase
    end

    assign load_half = mem_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];

    // funct3[2] marks the unsigned (LBU/LHU) variants.
    always_comb begin
        case (ls_width)
            LS_BYTE: load_data = funct3[2] ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            LS_HALF: load_data = funct3[2] ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_data = bus.data_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Next PC, writeback and load state
    // ---------------------------------------------------------------
    always_comb begin
        pc_next    = pc + 32'd4;
        state_next = ST_EXEC;
        rd_we      = 1'b0;
        rd_wdata   = alu_result;
        case (opcode)
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                pc_next  = pc + imm_j;
            end
            OP_JALR: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                pc_next  = (rs1_data + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (branch_taken(funct3, rs1_data, rs2_data)) begin
                    pc_next = pc + imm_b;
                end
            end
            OP_LOAD: begin
                if (load_ok) begin
                    if (state == ST_EXEC) begin
                        pc_next    = pc;
                        state_next = ST_LOAD_WAIT;
                    end else begin
                        rd_we    = 1'b1;
                        rd_wdata = load_data;
                    end
                end
            end
            OP_IMM, OP_OP: begin
                rd_we = 1'b1;
            end
            OP_STORE, OP_MISC_MEM, OP_SYSTEM: begin
                // No register write; the store strobe is driven below.
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= ST_EXEC;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // Bus outputs
    // ---------------------------------------------------------------
    assign bus.instr_addr        = pc;
    assign bus.debug_pc          = pc;
    assign bus.debug_instruction = instr;
    assign bus.data_addr         = mem_addr;
    assign bus.data_wdata        = store_wdata;
    assign bus.data_we           = store_ok && !rst;
    assign bus.data_be           = (store_ok && !rst) ? store_be : 4'b0000;

endmodule

// File: tb/tb_cpu_core_rv32i.sv
// Scoreboard bench for cpu_core_rv32i: per-cycle expectations (PC, store
// strobe/lanes/address/data) are queued when a program is loaded and popped
// on every falling edge; final register contents are checked afterwards.
module tb_cpu_core_rv32i;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cpu_core_rv32i_if bus ();

    cpu_core_rv32i #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    assign bus.instruction = imem[bus.instr_addr[9:2]];

    always @(posedge clk) begin
        bus.data_rdata <= dmem[bus.data_addr[9:2]];
        if (bus.data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be[b]) dmem[bus.data_addr[9:2]][8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
        end
    end

    int    errors = 0;
    int    checks = 0;
    string test_name = "";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t mon_e;
    logic mon_en = 1'b0;

    task automatic exp_cycle(input logic [31:0] pc);
        cyc_t e;
        e.pc = pc; e.we = 1'b0; e.be = 4'b0000; e.addr = '0; e.wdata = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_store(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        cyc_t e;
        e.pc = pc; e.we = 1'b1; e.be = be; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && (exp_q.size() > 0)) begin
            mon_e = exp_q.pop_front();
            check_eq({test_name, ".pc"}, bus.debug_pc, mon_e.pc);
            check_eq({test_name, ".instr"}, bus.debug_instruction, imem[mon_e.pc[9:2]]);
            check_eq({test_name, ".we"}, {31'd0, bus.data_we}, {31'd0, mon_e.we});
            check_eq({test_name, ".be"}, {28'd0, bus.data_be}, {28'd0, mon_e.be});
            if (mon_e.we) begin
                check_eq({test_name, ".st_addr"}, bus.data_addr, mon_e.addr);
                check_eq({test_name, ".st_wdata"}, bus.data_wdata, mon_e.wdata);
            end
        end
    end

    function automatic logic [31:0] xreg(input int n);
        return dut.reg_file.registers[n];
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'h0;
        end
        exp_q.delete();
    endtask

    task automatic run_prog(input string name, input int budget);
        int n;
        test_name = name;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        n = 0;
        while ((exp_q.size() > 0) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        mon_en = 1'b0;
        check_eq({name, ".drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state, with a store sitting at the reset PC ----
        clear_mem();
        imem[0] = enc_s(0, 0, 0, 2);
        test_name = "reset";
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset.pc", bus.debug_pc, 32'h0);
        check_eq("reset.we", {31'd0, bus.data_we}, 32'd0);
        check_eq("reset.be", {28'd0, bus.data_be}, 32'd0);
        check_eq("reset.x5", xreg(5), 32'h0);

        // ---- first instruction after reset ----
        clear_mem();
        imem[0] = addi(31, 0, 1);
        exp_cycle(32'h0); exp_cycle(32'h4); exp_cycle(32'h8);
        run_prog("first", 20);
        check_eq("first.x31", xreg(31), 32'h1);

        // ---- loads and stores ----
        clear_mem();
        imem[0]  = addi(1, 0, -1);
        imem[1]  = enc_s(3, 1, 0, 0);                      // SB x1,3(x0)
        imem[2]  = enc_i(3, 0, 0, 2, 7'b0000011);          // LB x2,3(x0)
        imem[3]  = enc_i(3, 0, 4, 3, 7'b0000011);          // LBU x3,3(x0)
        imem[4]  = addi(4, 0, 32'h123);
        imem[5]  = enc_s(6, 4, 0, 1);                      // SH x4,6(x0)
        imem[6]  = enc_i(6, 0, 1, 5, 7'b0000011);          // LH x5,6(x0)
        imem[7]  = enc_s(0, 1, 0, 1);                      // SH x1,0(x0)
        imem[8]  = enc_i(0, 0, 5, 6, 7'b0000011);          // LHU x6,0(x0)
        imem[9]  = enc_i(0, 0, 1, 7, 7'b0000011);          // LH x7,0(x0)
        imem[10] = enc_i(0, 0, 2, 8, 7'b0000011);          // LW x8,0(x0)
        imem[11] = enc_s(12, 8, 0, 2);                     // SW x8,12(x0)
        exp_cycle(32'h00);
        exp_store(32'h04, 32'h3, 4'b1000, 32'hFFFF_FFFF);
        exp_cycle(32'h08); exp_cycle(32'h08);
        exp_cycle(32'h0C); exp_cycle(32'h0C);
        exp_cycle(32'h10);
        exp_store(32'h14, 32'h6, 4'b1100, 32'h0123_0123);
        exp_cycle(32'h18); exp_cycle(32'h18);
        exp_store(32'h1C, 32'h0, 4'b0011, 32'hFFFF_FFFF);
        exp_cycle(32'h20); exp_cycle(32'h20);
        exp_cycle(32'h24); exp_cycle(32'h24);
        exp_cycle(32'h28); exp_cycle(32'h28);
        exp_store(32'h2C, 32'hC, 4'b1111, 32'hFF00_FFFF);
        exp_cycle(32'h30);
        run_prog("ldst", 60);
        check_eq("ldst.x2_lb", xreg(2), 32'hFFFF_FFFF);
        check_eq("ldst.x3_lbu", xreg(3), 32'h0000_00FF);
        check_eq("ldst.x5_lh_hi", xreg(5), 32'h0000_0123);
        check_eq("ldst.x6_lhu", xreg(6), 32'h0000_FFFF);
        check_eq("ldst.x7_lh", xreg(7), 32'hFFFF_FFFF);
        check_eq("ldst.x8_lw", xreg(8), 32'hFF00_FFFF);
        check_eq("ldst.mem3", dmem[3], 32'hFF00_FFFF);

        // ---- branches ----
        clear_mem();
        imem[0]  = addi(1, 0, 5);
        imem[1]  = addi(2, 0, 5);
        imem[2]  = enc_b(8, 2, 1, 0);                      // BEQ x1,x2,+8
        imem[3]  = addi(3, 0, 1);
        imem[4]  = enc_b(8, 2, 1, 1);                      // BNE x1,x2,+8
        imem[5]  = addi(4, 0, 2);
        imem[6]  = enc_b(8, 1, 0, 4);                      // BLT x0,x1,+8
        imem[7]  = addi(3, 0, 9);
        imem[8]  = addi(9, 0, -1);
        imem[9]  = enc_b(8, 1, 9, 7);                      // BGEU x9,x1,+8
        imem[10] = addi(3, 0, 7);
        imem[11] = enc_b(8, 1, 9, 5);                      // BGE x9,x1,+8
        exp_cycle(32'h00); exp_cycle(32'h04); exp_cycle(32'h08); exp_cycle(32'h10);
        exp_cycle(32'h14); exp_cycle(32'h18); exp_cycle(32'h20); exp_cycle(32'h24);
        exp_cycle(32'h2C); exp_cycle(32'h30);
        run_prog("branch", 40);
        check_eq("branch.x3_skipped", xreg(3), 32'h0);
        check_eq("branch.x4", xreg(4), 32'h2);

        // ---- jumps and upper immediates ----
        clear_mem();
        imem[0] = enc_j(16, 0);                            // JAL x0,+16
        imem[4] = enc_j(12, 1);                            // JAL x1,+12 @0x10
        imem[5] = enc_u(1, 6, 7'b0010111);                 // AUIPC x6,1 @0x14
        imem[6] = enc_u(32'hABCDE, 7, 7'b0110111);         // LUI x7 @0x18
        imem[7] = enc_i(1, 1, 0, 0, 7'b1100111);           // JALR x0,1(x1) @0x1C
        exp_cycle(32'h00); exp_cycle(32'h10); exp_cycle(32'h1C);
        exp_cycle(32'h14); exp_cycle(32'h18); exp_cycle(32'h1C);
        run_prog("jump", 30);
        check_eq("jump.x1_link", xreg(1), 32'h14);
        check_eq("jump.x6_auipc", xreg(6), 32'h0000_1014);
        check_eq("jump.x7_lui", xreg(7), 32'hABCD_E000);
        check_eq("jump.x0", xreg(0), 32'h0);

        // ---- ALU corners ----
        clear_mem();
        imem[0]  = addi(0, 0, 7);
        imem[1]  = enc_r(0, 0, 0, 0, 5);                   // ADD x5,x0,x0
        imem[2]  = enc_u(32'h80000, 10, 7'b0110111);       // LUI x10,0x80000
        imem[3]  = enc_i(32'h41F, 10, 5, 11, 7'b0010011);  // SRAI x11,x10,31
        imem[4]  = addi(12, 0, 1);
        imem[5]  = addi(13, 0, -1);
        imem[6]  = enc_r(0, 13, 12, 3, 14);                // SLTU x14,x12,x13
        imem[7]  = enc_r(0, 13, 12, 2, 15);                // SLT x15,x12,x13
        imem[8]  = enc_r(32, 13, 12, 0, 16);               // SUB x16,x12,x13
        imem[9]  = enc_i(31, 10, 5, 17, 7'b0010011);       // SRLI x17,x10,31
        imem[10] = enc_r(0, 13, 12, 1, 18);                // SLL x18,x12,x13
        imem[11] = enc_i(32'hF0, 13, 4, 19, 7'b0010011);   // XORI x19,x13,0xF0
        for (int i = 0; i <= 12; i++) exp_cycle(32'(4 * i));
        run_prog("alu", 40);
        check_eq("alu.x5", xreg(5), 32'h0);
        check_eq("alu.x11_srai", xreg(11), 32'hFFFF_FFFF);
        check_eq("alu.x14_sltu", xreg(14), 32'h1);
        check_eq("alu.x15_slt", xreg(15), 32'h0);
        check_eq("alu.x16_sub", xreg(16), 32'h2);
        check_eq("alu.x17_srli", xreg(17), 32'h1);
        check_eq("alu.x18_sll", xreg(18), 32'h8000_0000);
        check_eq("alu.x19_xori", xreg(19), 32'hFFFF_FF0F);

        // ---- reset during LOAD_WAIT ----
        clear_mem();
        imem[0] = addi(1, 0, 32'h55);
        imem[1] = enc_i(0, 0, 2, 1, 7'b0000011);           // LW x1,0(x0)
        dmem[0] = 32'h1234_5678;
        test_name = "rstld";
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstld.exec_pc", bus.debug_pc, 32'h4);
        @(posedge clk); #1;
        check_eq("rstld.wait_pc", bus.debug_pc, 32'h4);
        check_eq("rstld.wait_addr", bus.data_addr, 32'h0);
        check_eq("rstld.wait_we", {31'd0, bus.data_we}, 32'd0);
        check_eq("rstld.x1_before", xreg(1), 32'h55);
        rst = 1'b1;
        #1;
        check_eq("rstld.rst_we", {31'd0, bus.data_we}, 32'd0);
        @(posedge clk); #1;
        check_eq("rstld.pc", bus.debug_pc, 32'h0);
        check_eq("rstld.x1", xreg(1), 32'h0);
        check_eq("rstld.be", {28'd0, bus.data_be}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstld.resume_pc", bus.debug_pc, 32'h4);
        check_eq("rstld.resume_x1", xreg(1), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
